// File: rtl/song_sequencer.sv
// Step sequencer that walks a note ROM at a latched tempo after a silent lead-in,
// with pause/resume and a strobe delayed to cover the ROM's one-cycle read latency.
module song_sequencer #(
    parameter int BASE_TICKS = 50000000,
    parameter int SONG_LEN   = 95,
    parameter int LEAD_IN    = 4,
    parameter int IDX_W      = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic [1:0]       speed,
    input  logic [3:0]       notes_in,
    output logic [IDX_W-1:0] index,
    output logic [3:0]       notes_out,
    output logic             note_strobe,
    output logic             playing,
    output logic             done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_r, state_s, ret_r, ret_s;
    logic [31:0] cnt_r, lead_r, period_s;
    logic [1:0]  speed_l_r, shift_s;
    logic        start_q_r, start_edge_s, running_s, tick_s, last_s, lead_end_s;
    logic        restart_s, inc_s, play_evt_s, pend1_r, pend2_r;
    logic        playing_s, done_s;

    // Tempo, tick and event decode shared by the FSM and the datapath
    always_comb begin
        shift_s      = (speed_l_r == 2'd3) ? 2'd2 : speed_l_r;
        period_s     = 32'(BASE_TICKS) >> shift_s;
        start_edge_s = start & ~start_q_r;
        running_s    = (state_r == ST_LEAD) || (state_r == ST_PLAY);
        tick_s       = running_s && (cnt_r == period_s - 32'd1);
        last_s       = (index == IDX_W'(SONG_LEN - 1));
        lead_end_s   = ((lead_r + 32'd1) == 32'(LEAD_IN));
        restart_s    = start_edge_s && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        inc_s        = (state_r == ST_PLAY) && tick_s && !last_s;
        play_evt_s   = ((state_r == ST_LEAD) && tick_s && lead_end_s) ||
                       (restart_s && (LEAD_IN == 0));
    end

    // State register; the start copy resets high so a held start cannot trigger
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ret_r     <= ST_IDLE;
            start_q_r <= 1'b1;
        end else begin
            state_r   <= state_s;
            ret_r     <= ret_s;
            start_q_r <= start;
        end
    end

    // Next-state logic; a pause entered on a tick remembers where that tick led
    always_comb begin
        state_s = state_r;
        ret_s   = ret_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (restart_s) begin
                    state_s = (LEAD_IN == 0) ? ST_PLAY : ST_LEAD;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LEAD: begin
                if (pause) begin
                    state_s = ST_PAUSE;
                    ret_s   = (tick_s && lead_end_s) ? ST_PLAY : ST_LEAD;
                end else if (tick_s && lead_end_s) begin
                    state_s = ST_PLAY;
                end else begin
                    state_s = ST_LEAD;
                end
            end
            ST_PLAY: begin
                if (tick_s && last_s) begin
                    state_s = ST_DONE;
                end else if (pause) begin
                    state_s = ST_PAUSE;
                    ret_s   = ST_PLAY;
                end else begin
                    state_s = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (!pause) begin
                    state_s = ret_r;
                end else begin
                    state_s = ST_PAUSE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                ret_s   = ST_IDLE;
            end
        endcase
    end

    // Status output decode from the next state, registered below
    always_comb begin
        playing_s = (state_s == ST_LEAD) || (state_s == ST_PLAY);
        done_s    = (state_s == ST_DONE);
    end

    // Tick counter, lead count, ROM index and latched tempo
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r     <= 32'd0;
            lead_r    <= 32'd0;
            index     <= '0;
            speed_l_r <= 2'd0;
            playing   <= 1'b0;
            done      <= 1'b0;
        end else begin
            playing <= playing_s;
            done    <= done_s;
            if (restart_s) begin
                cnt_r     <= 32'd0;
                lead_r    <= 32'd0;
                index     <= '0;
                speed_l_r <= speed;
            end else if (running_s) begin
                cnt_r <= tick_s ? 32'd0 : cnt_r + 32'd1;
                if ((state_r == ST_LEAD) && tick_s) begin
                    lead_r <= lead_r + 32'd1;
                end
                if (inc_s) begin
                    index <= index + IDX_W'(1);
                end
            end
        end
    end

    // Strobe pipeline: ROM data is sampled two edges after each index event
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend1_r     <= 1'b0;
            pend2_r     <= 1'b0;
            notes_out   <= 4'd0;
            note_strobe <= 1'b0;
        end else begin
            pend1_r <= inc_s | play_evt_s;
            pend2_r <= pend1_r;
            if (pend2_r) begin
                notes_out   <= notes_in;
                note_strobe <= 1'b1;
            end else begin
                note_strobe <= 1'b0;
                if (state_r == ST_DONE) begin
                    notes_out <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: the reference model tracks elapsed running cycles
// since start and derives index, state and strobe times arithmetically.
module tb_song_sequencer;
    localparam int BT = 8;
    localparam int SL = 6;
    localparam int LI = 2;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic [1:0]    speed = 2'd0;
    logic [3:0]    notes_in = 4'd0;
    logic [IW-1:0] index;
    logic [3:0]    notes_out;
    logic          note_strobe, playing, done;
    logic [IW+6:0] dut_v;

    song_sequencer #(.BASE_TICKS(BT), .SONG_LEN(SL), .LEAD_IN(LI), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .speed(speed),
        .notes_in(notes_in), .index(index), .notes_out(notes_out),
        .note_strobe(note_strobe), .playing(playing), .done(done)
    );

    always #5 clk = ~clk;
    assign dut_v = {index, notes_out, note_strobe, playing, done};

    logic [3:0] rom [0:(1<<IW)-1];
    always @(posedge clk) notes_in <= rom[index];

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_active, m_paused, m_done, m_sp, m_strobe;
    int       m_t, m_period, m_idx, cyc_n;
    logic [3:0] m_notes;
    int       q_due[$];
    int       q_val[$];

    function automatic void model_clear();
        m_active = 1'b0; m_paused = 1'b0; m_done = 1'b0; m_sp = 1'b1; m_strobe = 1'b0;
        m_t = 0; m_period = BT; m_idx = 0; m_notes = 4'd0;
        q_due.delete(); q_val.delete();
    endfunction

    function automatic logic [IW+6:0] exp_vec();
        return {IW'(m_idx), m_notes, m_strobe, m_active && !m_paused, m_done};
    endfunction

    task automatic model_edge();
        bit se, was_done;
        int k;
        cyc_n++;
        if (reset) begin
            model_clear();
            return;
        end
        se = start && !m_sp;
        m_sp = start;
        was_done = m_done;
        m_strobe = 1'b0;
        if (q_due.size() > 0 && q_due[0] == cyc_n - 1) begin
            m_strobe = 1'b1;
            m_notes = rom[q_val[0]];
            void'(q_due.pop_front());
            void'(q_val.pop_front());
        end else if (was_done) begin
            m_notes = 4'd0;
        end
        if (m_active && !m_paused) begin
            m_t++;
            if (m_t % m_period == 0 && m_t >= LI * m_period) begin
                k = m_t / m_period - LI;
                if (k < SL) begin
                    m_idx = k;
                    q_due.push_back(cyc_n - 1 + 2);
                    q_val.push_back(k);
                end else begin
                    m_done = 1'b1;
                    m_active = 1'b0;
                end
            end
            if (m_active && pause) m_paused = 1'b1;
        end else if (m_active) begin
            if (!pause) m_paused = 1'b0;
        end else if (se) begin
            m_active = 1'b1; m_paused = 1'b0; m_done = 1'b0; m_t = 0; m_idx = 0;
            m_period = BT >> ((speed == 2'd3) ? 2 : int'(speed));
        end
    endtask

    // One clock: model follows the edge, outputs then settle until the falling edge
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pause = 1'b0;
        model_clear();
        cyc(); cyc();
        checks++;
        if (dut_v !== '0) begin
            errors++; $display("FAIL reset_state: got %h expected 0", dut_v);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL reset_idle: got %h expected %h", dut_v, exp_vec());
            end
        end
    endtask

    task automatic test_basic();
        int s0;
        int st[$];
        speed = 2'd0; start = 1'b1; s0 = cyc_n;
        for (int i = 0; i < 80; i++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL basic_cycle%0d: got %h expected %h", i, dut_v, exp_vec());
            end
            if (note_strobe) st.push_back(cyc_n - 1);
            if (i == 0) start = 1'b0;
        end
        checks++;
        if (st.size() != SL) begin
            errors++; $display("FAIL basic_strobe_count: got %0d expected %0d", st.size(), SL);
        end
        if (st.size() > 0) begin
            checks++;
            if (st[0] - s0 != LI * BT + 2) begin
                errors++; $display("FAIL basic_first_strobe: got %0d expected %0d", st[0] - s0, LI * BT + 2);
            end
        end
        for (int i = 1; i < st.size(); i++) begin
            checks++;
            if (st[i] - st[i-1] != BT) begin
                errors++; $display("FAIL basic_spacing: got %0d expected %0d", st[i] - st[i-1], BT);
            end
        end
        checks++;
        if ({done, index, notes_out} !== {1'b1, IW'(SL - 1), 4'd0}) begin
            errors++; $display("FAIL basic_end: got done=%b index=%0d notes=%h expected 1/%0d/0",
                               done, index, notes_out, SL - 1);
        end
    endtask

    task automatic test_speed();
        int st[$];
        for (int sp = 2; sp <= 3; sp++) begin
            st.delete();
            speed = 2'(sp); start = 1'b1;
            for (int i = 0; i < 40; i++) begin
                cyc();
                checks++;
                if (dut_v !== exp_vec()) begin
                    errors++; $display("FAIL speed%0d_cycle%0d: got %h expected %h", sp, i, dut_v, exp_vec());
                end
                if (note_strobe) st.push_back(cyc_n - 1);
                if (i == 0) start = 1'b0;
                if (i == 6) speed = 2'd0;
            end
            checks++;
            if (st.size() != SL) begin
                errors++; $display("FAIL speed%0d_count: got %0d expected %0d", sp, st.size(), SL);
            end
            for (int i = 1; i < st.size(); i++) begin
                checks++;
                if (st[i] - st[i-1] != (BT >> 2)) begin
                    errors++; $display("FAIL speed%0d_spacing: got %0d expected %0d", sp, st[i] - st[i-1], BT >> 2);
                end
            end
        end
    endtask

    task automatic test_pause();
        int n, s3, s4, budget;
        speed = 2'd0; start = 1'b1; n = 0; s3 = -1; s4 = -1;
        for (budget = 0; budget < 100 && n < 3; budget++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL pause_pre: got %h expected %h", dut_v, exp_vec());
            end
            if (note_strobe) begin n++; s3 = cyc_n - 1; end
            start = 1'b0;
        end
        checks++;
        if (n < 3) begin
            errors++; $display("FAIL pause_wait3: got %0d strobes expected 3", n);
        end
        pause = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec() || note_strobe !== 1'b0 || index !== IW'(2)) begin
                errors++; $display("FAIL pause_hold%0d: got %h expected %h", i, dut_v, exp_vec());
            end
        end
        pause = 1'b0;
        for (budget = 0; budget < 40 && s4 < 0; budget++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL pause_resume: got %h expected %h", dut_v, exp_vec());
            end
            if (note_strobe) s4 = cyc_n - 1;
        end
        checks++;
        if (s4 - s3 != BT + 20) begin
            errors++; $display("FAIL pause_gap: got %0d expected %0d", s4 - s3, BT + 20);
        end
        for (int i = 0; i < 60; i++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL pause_tail: got %h expected %h", dut_v, exp_vec());
            end
        end
    endtask

    task automatic test_start_ignored();
        int n;
        n = 0; speed = 2'd0; start = 1'b1;
        for (int i = 0; i < 90; i++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL ignore_cycle%0d: got %h expected %h", i, dut_v, exp_vec());
            end
            if (note_strobe) n++;
            case (i)
                0, 8, 27, 44: start = 1'b0;
                4, 25, 42:    start = 1'b1;
                40:           pause = 1'b1;
                46:           pause = 1'b0;
                default:      ;
            endcase
        end
        checks++;
        if (n != SL || done !== 1'b1 || index !== IW'(SL - 1)) begin
            errors++; $display("FAIL ignore_end: got strobes=%0d done=%b index=%0d expected %0d/1/%0d",
                               n, done, index, SL, SL - 1);
        end
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL replay_cycle%0d: got %h expected %h", i, dut_v, exp_vec());
            end
            start = 1'b0;
        end
        checks++;
        if (index !== IW'(0) || notes_out !== rom[0] || playing !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL replay_first: got index=%0d notes=%h playing=%b expected 0/%h/1",
                               index, notes_out, playing, rom[0]);
        end
    endtask

    task automatic test_reset_mid();
        int n, budget;
        reset = 1'b1; model_clear(); cyc(); reset = 1'b0; cyc();
        start = 1'b1; n = 0;
        for (budget = 0; budget < 100 && n < 2; budget++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL rmid_pre: got %h expected %h", dut_v, exp_vec());
            end
            if (note_strobe) n++;
            start = 1'b0;
        end
        cyc(); cyc(); cyc();
        start = 1'b1; reset = 1'b1; model_clear();
        #1;
        checks++;
        if (dut_v !== '0) begin
            errors++; $display("FAIL rmid_async: got %h expected 0", dut_v);
        end
        cyc(); cyc();
        reset = 1'b0; n = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL rmid_held: got %h expected %h", dut_v, exp_vec());
            end
            if (note_strobe || playing) n++;
        end
        checks++;
        if (n != 0) begin
            errors++; $display("FAIL rmid_idle: got %0d active cycles expected 0", n);
        end
        start = 1'b0; cyc(); start = 1'b1; cyc();
        checks++;
        if (playing !== 1'b1 || dut_v !== exp_vec()) begin
            errors++; $display("FAIL rmid_restart: got %h expected %h", dut_v, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) start = ~start;
            if ($urandom_range(0, 11) == 0) pause = ~pause;
            if ($urandom_range(0, 7) == 0) speed = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 499) == 0);
            if (reset) model_clear();
            cyc();
            checks++;
            if (dut_v !== exp_vec()) begin
                errors++; $display("FAIL random_cycle%0d: got %h expected %h", i, dut_v, exp_vec());
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << IW); i++) rom[i] = 4'($urandom);
        cyc_n = 0;
        model_clear();
        test_reset();
        test_basic();
        test_speed();
        test_pause();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 Parameter BASE_TICKS, default 50000000, SHALL be the clock cycles per note step at speed 0.
REQ-002 Parameter SONG_LEN, default 95, SHALL be the number of note slots played (indices 0..SONG_LEN-1).
REQ-003 Parameter LEAD_IN, default 4, SHALL be the count of silent steps before index 0.
REQ-004 Parameter IDX_W, default 7, SHALL be the width of index.
REQ-005 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 reset  in  1  SHALL be the reset: asynchronous and active-high.
REQ-007 start  in  1  SHALL be a level; its rising edge requests playback.
REQ-008 pause  in  1  SHALL be a level; while high, playback freezes.
REQ-009 speed  in  2  SHALL be the tempo select, latched at start.
REQ-010 notes_in  in  4  SHALL be the note-ROM data, valid 1 cycle after index changes.
REQ-011 index  out  IDX_W  SHALL be the note-ROM address.
REQ-012 notes_out  out  4  SHALL be the registered lane bitmap of the current step.
REQ-013 note_strobe  out  1  SHALL be a one-cycle pulse marking notes_out updated.
REQ-014 playing  out  1  SHALL be high in LEAD and PLAY states.
REQ-015 done  out  1  SHALL be high in DONE state.

Function
REQ-016 States SHALL be IDLE, LEAD, PLAY, PAUSE, DONE.
REQ-017 Step period SHALL be BASE_TICKS>>speed_l, where speed_l is the latched speed and a value of 3 is treated as 2.
REQ-018 Tick counter SHALL count 0..period-1 in LEAD and PLAY; the cycle it equals period-1 is a step tick and it wraps to 0.
REQ-019 Start edge detection SHALL use a registered copy of start; a rising edge is start high and the copy low.
REQ-020 IDLE or DONE with a start edge SHALL go to LEAD, clear the counter, set index=0, set the lead count=0 and latch speed.
REQ-021 A start edge in LEAD, PLAY or PAUSE SHALL be ignored.
REQ-022 In LEAD, each step tick SHALL increment the lead count; at the tick where the count reaches LEAD_IN, the block SHALL enter PLAY; LEAD_IN=0 SHALL enter PLAY directly.
REQ-023 LEAD SHALL produce no note_strobe.
REQ-024 On entering PLAY, the first note_strobe for index 0 SHALL occur 2 cycles later, with notes_out = notes_in sampled at that edge.
REQ-025 On each PLAY step tick with index < SONG_LEN-1, index SHALL increment.
REQ-026 Exactly 2 cycles after each index increment, one note_strobe SHALL occur with notes_out = ROM[index].
REQ-027 On the step tick with index = SONG_LEN-1, the block SHALL enter DONE, hold index, and clear notes_out next cycle with no strobe.
REQ-028 pause high in LEAD or PLAY SHALL enter PAUSE next cycle, saving the return state; counter, index and notes_out SHALL hold.
REQ-029 pause low in PAUSE SHALL return to the saved state; counting SHALL resume from the held value.
REQ-030 A step tick coinciding with pause rising SHALL be honoured (index advances) before the block enters PAUSE.
REQ-031 An in-flight strobe, 2 cycles after an index change, SHALL still issue if a pause begins in between.
REQ-032 In DONE, index and done SHALL hold until a start edge or reset.

Reset
REQ-033 On reset, the block SHALL immediately go to IDLE: index=0, notes_out=0, note_strobe=0, playing=0, done=0, counter=0, speed_l=0, and the start copy =1 so that a held start does not trigger.
REQ-034 Reset mid-playback SHALL abort with no further strobes; leaving reset SHALL not start playback.

Verification (BASE_TICKS=8, SONG_LEN=6, LEAD_IN=2, ROM model 1-cycle latency)
REQ-035 Start pulse, speed=0 -> playing=1, 16 cycles of LEAD, then 6 strobes spaced 8 cycles carrying ROM[0..5], then done=1 with index=5 and notes_out=0.
REQ-036 speed=2 and, separately, speed=3 -> strobe spacing 2 cycles in both runs; changing speed mid-play -> spacing unchanged.
REQ-037 pause held 20 cycles after the 3rd strobe -> no strobes and index=2 frozen; after release, the next strobe arrives 8-(elapsed count) cycles later.
REQ-038 Start edges during LEAD, PLAY and PAUSE -> no effect; start edge in DONE -> full replay from index 0.
REQ-039 Reset asserted between the 2nd and 3rd strobes -> all outputs 0 asynchronously; start held high through reset release -> stays IDLE until start toggles low then high.
